// File: rtl/i2c_slave_rx.sv
`default_nettype none
// i2c_slave_rx: write-only 7-bit-address I2C slave receiver, no clock stretching (rev 1.0).
// Define I2C_SLAVE_MULTIBYTE_EN to accept and ACK any number of data bytes per transfer.
module i2c_slave_rx #(
  parameter logic [6:0] SLAVE_ADDR = 7'b1010000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       busy,
  output logic       addr_match
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR      = 3'd1,
    ADDR_ACK  = 3'd2,
    DATA      = 3'd3,
    DATA_ACK  = 3'd4,
    WAIT_STOP = 3'd5
  } state_t;

  logic       scl_meta_q, scl_sync_q, scl_prev_q;
  logic       sda_meta_q, sda_sync_q, sda_prev_q;
  state_t     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] data_out_q, data_out_d;
  logic       data_valid_q, data_valid_d;
  logic       busy_q, busy_d;
  logic       addr_match_q, addr_match_d;

  logic scl_rise, scl_fall, start_det, stop_det;

  always_comb begin
    scl_rise     = scl_sync_q & ~scl_prev_q;
    scl_fall     = ~scl_sync_q & scl_prev_q;
    // scl must be high on both samples so a simultaneous scl/sda edge is not misread
    start_det    = scl_sync_q & scl_prev_q & sda_prev_q & ~sda_sync_q;
    stop_det     = scl_sync_q & scl_prev_q & ~sda_prev_q & sda_sync_q;

    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    sda_oe_d     = sda_oe_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    busy_d       = busy_q;
    addr_match_d = addr_match_q;

    if (start_det) begin
      state_d      = ADDR;
      shift_d      = 8'h00;
      bit_cnt_d    = 4'd0;
      sda_oe_d     = 1'b0;
      busy_d       = 1'b1;
      addr_match_d = 1'b0;
    end else if (stop_det) begin
      state_d      = IDLE;
      sda_oe_d     = 1'b0;
      busy_d       = 1'b0;
      addr_match_d = 1'b0;
    end else begin
      case (state_q)
        ADDR: begin
          if (scl_rise && bit_cnt_q < 4'd8) begin
            shift_d   = {shift_q[6:0], sda_sync_q};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            if (shift_q[7:1] == SLAVE_ADDR && !shift_q[0]) begin
              state_d      = ADDR_ACK;
              sda_oe_d     = 1'b1;
              addr_match_d = 1'b1;
            end else begin
              state_d      = WAIT_STOP;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            state_d   = DATA;
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
          end
        end
        DATA: begin
          if (scl_rise && bit_cnt_q < 4'd8) begin
            shift_d   = {shift_q[6:0], sda_sync_q};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              data_out_d   = {shift_q[6:0], sda_sync_q};
              data_valid_d = 1'b1;
            end
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            state_d  = DATA_ACK;
            sda_oe_d = 1'b1;
          end
        end
        DATA_ACK: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
`ifdef I2C_SLAVE_MULTIBYTE_EN
            state_d   = DATA;
`else
            state_d   = WAIT_STOP;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      scl_meta_q   <= 1'b1;
      scl_sync_q   <= 1'b1;
      scl_prev_q   <= 1'b1;
      sda_meta_q   <= 1'b1;
      sda_sync_q   <= 1'b1;
      sda_prev_q   <= 1'b1;
      state_q      <= IDLE;
      shift_q      <= 8'h00;
      bit_cnt_q    <= 4'd0;
      sda_oe_q     <= 1'b0;
      data_out_q   <= 8'h00;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      addr_match_q <= 1'b0;
    end else begin
      scl_meta_q   <= scl;
      scl_sync_q   <= scl_meta_q;
      scl_prev_q   <= scl_sync_q;
      sda_meta_q   <= sda;
      sda_sync_q   <= sda_meta_q;
      sda_prev_q   <= sda_sync_q;
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      sda_oe_q     <= sda_oe_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      busy_q       <= busy_d;
      addr_match_q <= addr_match_d;
    end
  end

  assign sda        = sda_oe_q ? 1'b0 : 1'bz;
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign busy       = busy_q;
  assign addr_match = addr_match_q;

endmodule
`default_nettype wire
